line_burst_adaptor: RTL and testbench

- Downstream neighbour of the cache.
- Converts the cache's single 256-bit line read/writeback requests into 4-beat, 64-bit burst transactions on the physical-memory port.
- Returns one 256-bit line response.
- Sits between the cache's pmem_* ports and main memory; only one transaction is outstanding at a time.

---
 rtl/line_burst_adaptor.sv | 97 +++++++++
 tb/tb_line_burst_adaptor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adaptor.sv
// Splits a 256-bit cache line request into four 64-bit memory beats.
// It handles one transaction at a time and returns one 256-bit line response.
module line_burst_adaptor #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int num_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beat_w = $clog2(num_beats);
  localparam int off_w  = $clog2(s_line / 8);
  localparam logic [beat_w-1:0] last_beat = beat_w'(num_beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [beat_w-1:0]   beat;
  logic [s_line-1:0]   wbuf;
  logic                beat_accept;

  assign beat_accept = resp_i && (state == READ || state == WRITE);

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = '0;
    unique case (state)
      IDLE: begin
        if (read_i)       state_next = READ;
        else if (write_i) state_next = WRITE;
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && beat == last_beat) state_next = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = wbuf[s_burst*beat +: s_burst];
        if (resp_i && beat == last_beat) state_next = DONE;
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (read_i || write_i)) begin
        address_o <= {address_i[31:off_w], off_w'(0)};
        beat      <= '0;
      end else if (beat_accept) begin
        beat <= beat + 1'b1;  // wraps to 0 on the final beat
      end
      if (state == READ && resp_i)
        line_o[s_burst*beat +: s_burst] <= burst_i;
    end
  end

  // NOTE: the write buffer is reset-free data storage. It is always loaded before WRITE reads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && write_i && !read_i)
      wbuf <= line_i;
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor.
// It covers reads with and without stalls, writes, read priority, back-to-back transfers and mid-burst reset.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int tests  = 0;
  int failed = 0;

  line_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs a full read with beats on consecutive cycles, then drops read_i when resp_o is seen.
  task automatic run_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [255:0] data);
    address_i = addr;
    read_i    = 1'b1;
    tick();
    check({tag, "_read_o"}, read_o, 1);
    check({tag, "_write_o"}, write_o, 0);
    check({tag, "_addr"}, address_o, exp_addr);
    for (int i = 0; i < 4; i++) begin
      resp_i  = 1'b1;
      burst_i = data[64*i +: 64];
      tick();
      if (i < 3) begin
        check({tag, "_resp_early"}, resp_o, 0);
        check({tag, "_read_held"}, read_o, 1);
      end
    end
    check({tag, "_resp"}, resp_o, 1);
    check({tag, "_read_done"}, read_o, 0);
    check({tag, "_line"}, line_o, data);
    read_i = 1'b0;
    resp_i = 1'b0;
    tick();
    check({tag, "_resp_once"}, resp_o, 0);
  endtask

  logic [255:0] wline, rline, sline;
  logic [1:0]   stall_hits;

  initial begin
    wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    rline = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    tick();
    check("rst_line_o", line_o, 0);
    check("rst_burst_o", burst_o, 0);
    check("rst_addr_o", address_o, 0);
    check("rst_ctrl", {read_o, write_o, resp_o}, 0);
    rst = 1'b0;
    tick();

    // Read with back-to-back beats
    run_read("rd_b2b", 32'h1234_567F, 32'h1234_5660, rline);

    // Read with stalls: resp_i = 1,0,0,1,1,0,1
    sline = {64'h0F0F_0000_0000_0003, 64'h0F0F_0000_0000_0002,
             64'h0F0F_0000_0000_0001, 64'h0F0F_0000_0000_0000};
    address_i = 32'h0000_1010;
    read_i    = 1'b1;
    tick();
    check("rd_stall_addr", address_o, 32'h0000_1000);
    stall_hits = 2'd0;
    for (int i = 0; i < 7; i++) begin
      resp_i = (i == 0 || i == 3 || i == 4 || i == 6);
      burst_i = resp_i ? sline[64*stall_hits +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (resp_i) stall_hits++;
      tick();
      if (i < 6) check("rd_stall_no_resp", resp_o, 0);
    end
    check("rd_stall_resp", resp_o, 1);
    check("rd_stall_line", line_o, sline);
    read_i  = 1'b0;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;  // resp_i still high in DONE/IDLE must be ignored
    tick();
    check("rd_stall_resp_once", resp_o, 0);
    tick();
    check("idle_resp_ignored_line", line_o, sline);
    check("idle_resp_ignored_ctrl", {read_o, write_o, resp_o}, 0);
    resp_i = 1'b0;

    // Write, line_i cleared after capture, one stall before the first accept
    line_i    = wline;
    address_i = 32'h8000_0023;
    write_i   = 1'b1;
    tick();
    line_i    = '0;
    address_i = 32'hFFFF_FFFF;
    check("wr_write_o", write_o, 1);
    check("wr_read_o", read_o, 0);
    check("wr_addr", address_o, 32'h8000_0020);
    check("wr_beat0", burst_o, {16{4'hA}});
    tick();
    check("wr_stall_beat0", burst_o, {16{4'hA}});
    resp_i = 1'b1;
    tick();
    check("wr_beat1", burst_o, {16{4'hB}});
    tick();
    check("wr_beat2", burst_o, {16{4'hC}});
    tick();
    check("wr_beat3", burst_o, {16{4'hD}});
    check("wr_no_early_resp", resp_o, 0);
    tick();
    check("wr_resp", resp_o, 1);
    check("wr_done_ctrl", {read_o, write_o}, 0);
    check("wr_addr_held", address_o, 32'h8000_0020);
    write_i = 1'b0;
    resp_i  = 1'b0;
    tick();
    check("wr_resp_once", resp_o, 0);

    // Back-to-back: read requested the cycle after the write completed
    run_read("b2b_rd", 32'h0000_0047, 32'h0000_0040,
             {64'hE3, 64'hE2, 64'hE1, 64'hE0});

    // Read and write requested together: read wins
    line_i  = wline;
    write_i = 1'b1;
    run_read("both", 32'h0000_2000, 32'h0000_2000, ~rline);
    write_i = 1'b0;
    check("both_no_write", write_o, 0);

    // Reset during write beat 2 aborts with no response
    line_i    = wline;
    address_i = 32'h0000_3000;
    write_i   = 1'b1;
    tick();
    resp_i = 1'b1;
    tick();
    tick();
    check("abort_beat2", burst_o, {16{4'hC}});
    resp_i = 1'b0;
    rst    = 1'b1;
    tick();
    check("abort_ctrl", {read_o, write_o, resp_o}, 0);
    check("abort_addr", address_o, 0);
    check("abort_line", line_o, 0);
    check("abort_burst", burst_o, 0);
    rst     = 1'b0;
    write_i = 1'b0;
    tick();
    check("abort_no_resp", resp_o, 0);
    run_read("post_abort", 32'h0000_4020, 32'h0000_4020, rline);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
